// File: rtl/gray3_seq_checker_if.sv
// Bus between a 3-bit Gray-code counter (master) and gray3_seq_checker (slave).
// The code word plus its qualifier go one way; the checker's status comes back.
interface gray3_seq_checker_if #(
    parameter int ERR_W = 8
);
    // Handshake: in_valid qualifies code for exactly the cycle it is high. There is
    // no back-pressure (no ready), and cycles with in_valid low carry no information.
    logic             in_valid;
    logic [2:0]       code;
    logic [2:0]       index;
    logic             locked;
    logic             err;
    logic [ERR_W-1:0] err_count;
    logic             stuck;

    modport master (
        output in_valid, code,
        input  index, locked, err, err_count, stuck
    );

    modport slave (
        input  in_valid, code,
        output index, locked, err, err_count, stuck
    );
endinterface

// File: rtl/gray3_seq_checker.sv
// Receive-side tracker for the 3-bit Gray counter sequence: decode, lock, count errors.
// Optional hold/stuck detector is enabled by defining GRAY3_CHK_STUCK_EN.
module gray3_seq_checker #(
    parameter int ERR_W     = 8,
    parameter int LOCK_CNT  = 3,
    parameter int STUCK_MAX = 16
) (
    input  logic                 clk,
    input  logic                 clr,
    gray3_seq_checker_if.slave   bus,
    output logic [1:0]           o_dbg_state
);

    typedef enum logic [1:0] {
        ST_HUNT = 2'd0,
        ST_ACQ  = 2'd1,
        ST_LOCK = 2'd2
    } state_t;

    function automatic logic [2:0] gray2bin(input logic [2:0] g);
        return {g[2], g[2] ^ g[1], g[2] ^ g[1] ^ g[0]};
    endfunction

    function automatic logic [2:0] bin2gray(input logic [2:0] b);
        return b ^ {1'b0, b[2:1]};
    endfunction

    state_t           r_state;
    logic [2:0]       r_ref;
    logic [2:0]       r_good;
    logic [2:0]       r_index;
    logic             r_locked;
    logic             r_err;
    logic [ERR_W-1:0] r_err_count;

    state_t           w_state_nxt;
    logic [2:0]       w_good_nxt;
    logic             w_locked_nxt;
    logic             w_err_nxt;
    logic [2:0]       w_succ;
    logic [2:0]       w_good_inc;
    logic             w_is_good;
    logic             w_is_hold;
    logic             w_is_bad;

    // Successor of the reference: step in the binary domain, then re-encode.
    assign w_succ     = bin2gray(gray2bin(r_ref) + 3'd1);
    assign w_good_inc = r_good + 3'd1;
    assign w_is_good  = bus.in_valid && (bus.code == w_succ);
    assign w_is_hold  = bus.in_valid && (bus.code == r_ref);
    assign w_is_bad   = bus.in_valid && !w_is_good && !w_is_hold;

    always_comb begin
        w_state_nxt  = r_state;
        w_good_nxt   = r_good;
        w_locked_nxt = r_locked;
        w_err_nxt    = 1'b0;
        if (bus.in_valid) begin
            case (r_state)
                ST_HUNT: begin
                    w_state_nxt = ST_ACQ;
                    w_good_nxt  = 3'd0;
                end
                ST_ACQ: begin
                    if (w_is_good) begin
                        w_good_nxt = w_good_inc;
                        if (w_good_inc == 3'(LOCK_CNT)) begin
                            w_state_nxt  = ST_LOCK;
                            w_locked_nxt = 1'b1;
                        end
                    end else if (w_is_bad) begin
                        w_good_nxt = 3'd0;
                    end
                end
                ST_LOCK: begin
                    if (w_is_bad) begin
                        w_err_nxt    = 1'b1;
                        w_good_nxt   = 3'd0;
                        w_locked_nxt = 1'b0;
                        w_state_nxt  = ST_ACQ;
                    end
                end
                default: begin
                    w_state_nxt  = ST_HUNT;
                    w_good_nxt   = 3'd0;
                    w_locked_nxt = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_state     <= ST_HUNT;
            r_ref       <= 3'd0;
            r_good      <= 3'd0;
            r_index     <= 3'd0;
            r_locked    <= 1'b0;
            r_err       <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_good   <= w_good_nxt;
            r_locked <= w_locked_nxt;
            // err is a pulse: it drops on the next edge even if that cycle is not valid.
            r_err    <= w_err_nxt;
            if (bus.in_valid) begin
                r_ref   <= bus.code;
                r_index <= gray2bin(bus.code);
            end
            if (w_err_nxt && (r_err_count != {ERR_W{1'b1}})) begin
                r_err_count <= r_err_count + 1'b1;
            end
        end
    end

`ifdef GRAY3_CHK_STUCK_EN
    logic [7:0] r_hold;
    logic       r_stuck;
    logic [7:0] w_hold_nxt;

    always_comb begin
        w_hold_nxt = r_hold;
        if (bus.in_valid) begin
            if (r_state == ST_HUNT) begin
                w_hold_nxt = 8'd0;
            end else if (w_is_hold) begin
                if (r_hold != 8'(STUCK_MAX)) begin
                    w_hold_nxt = r_hold + 8'd1;
                end
            end else begin
                w_hold_nxt = 8'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            r_hold  <= 8'd0;
            r_stuck <= 1'b0;
        end else begin
            r_hold  <= w_hold_nxt;
            r_stuck <= (w_hold_nxt == 8'(STUCK_MAX));
        end
    end

    assign bus.stuck = r_stuck;
`else
    assign bus.stuck = 1'b0;
`endif

    assign bus.index     = r_index;
    assign bus.locked    = r_locked;
    assign bus.err       = r_err;
    assign bus.err_count = r_err_count;
    assign o_dbg_state   = r_state;

endmodule

// File: tb/tb_gray3_seq_checker.sv
// Directed self-checking bench for gray3_seq_checker: one task per scenario, inline checks.
// A second instance with ERR_W=2 shares the stimulus to exercise counter saturation.
module tb_gray3_seq_checker;

  logic       clk;
  logic       clr;
  logic       tb_valid;
  logic [2:0] tb_code;
  logic [1:0] dbg_state;
  logic [1:0] dbg_state_s;
  int         checks;
  int         errors;

  gray3_seq_checker_if #(.ERR_W(8)) bus ();
  gray3_seq_checker_if #(.ERR_W(2)) bus_s ();

  assign bus.in_valid   = tb_valid;
  assign bus.code       = tb_code;
  assign bus_s.in_valid = tb_valid;
  assign bus_s.code     = tb_code;

  gray3_seq_checker #(.ERR_W(8), .LOCK_CNT(3), .STUCK_MAX(16)) dut (
    .clk         (clk),
    .clr         (clr),
    .bus         (bus),
    .o_dbg_state (dbg_state)
  );

  gray3_seq_checker #(.ERR_W(2), .LOCK_CNT(3), .STUCK_MAX(16)) dut_s (
    .clk         (clk),
    .clr         (clr),
    .bus         (bus_s),
    .o_dbg_state (dbg_state_s)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // driver tasks: inputs change on negedge, outputs checked 1 time unit after posedge
  task automatic step(input logic v, input logic [2:0] c);
    @(negedge clk);
    tb_valid = v;
    tb_code  = c;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clr      = 1'b1;
    tb_valid = 1'b0;
    tb_code  = 3'd0;
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic lock_to_010();
    step(1'b1, 3'b000);
    step(1'b1, 3'b001);
    step(1'b1, 3'b011);
    step(1'b1, 3'b010);
  endtask

  task automatic test_reset();
    clr      = 1'b1;
    tb_valid = 1'b0;
    tb_code  = 3'd0;
    @(posedge clk);
    #1;
    checks++;
    if (bus.index !== 3'd0 || bus.locked !== 1'b0 || bus.err !== 1'b0 ||
        bus.err_count !== 8'd0 || bus.stuck !== 1'b0 || dbg_state !== 2'd0) begin
      $display("FAIL reset_outputs got idx=%0d lk=%0b err=%0b cnt=%0d stk=%0b st=%0d want all 0",
               bus.index, bus.locked, bus.err, bus.err_count, bus.stuck, dbg_state);
      errors++;
    end
    @(negedge clk);
    clr = 1'b0;
  endtask

  task automatic test_lockup();
    logic [2:0] codes [9];
    logic [2:0] idx   [9];
    logic       lk    [9];
    codes = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    idx   = '{3'd0, 3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    lk    = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    do_reset();
    for (int i = 0; i < 9; i++) begin
      step(1'b1, codes[i]);
      checks++;
      if (bus.index !== idx[i]) begin
        $display("FAIL lockup_index step %0d got %0d want %0d", i, bus.index, idx[i]);
        errors++;
      end
      checks++;
      if (bus.locked !== lk[i]) begin
        $display("FAIL lockup_locked step %0d got %0b want %0b", i, bus.locked, lk[i]);
        errors++;
      end
      checks++;
      if (bus.err !== 1'b0) begin
        $display("FAIL lockup_err step %0d got %0b want 0", i, bus.err);
        errors++;
      end
    end
    checks++;
    if (dbg_state !== 2'd2) begin
      $display("FAIL lockup_state got %0d want 2", dbg_state);
      errors++;
    end
  endtask

  task automatic test_error_relock();
    do_reset();
    step(1'b1, 3'b100);
    step(1'b1, 3'b000);
    step(1'b1, 3'b001);
    step(1'b1, 3'b011);
    checks++;
    if (bus.locked !== 1'b1) begin
      $display("FAIL relock_pre_locked got %0b want 1", bus.locked);
      errors++;
    end
    step(1'b1, 3'b000);
    checks++;
    if (bus.err !== 1'b1 || bus.err_count !== 8'd1 || bus.locked !== 1'b0 || bus.index !== 3'd0) begin
      $display("FAIL relock_bad got err=%0b cnt=%0d lk=%0b idx=%0d want err=1 cnt=1 lk=0 idx=0",
               bus.err, bus.err_count, bus.locked, bus.index);
      errors++;
    end
    step(1'b1, 3'b001);
    checks++;
    if (bus.err !== 1'b0 || bus.locked !== 1'b0) begin
      $display("FAIL relock_pulse_end got err=%0b lk=%0b want err=0 lk=0", bus.err, bus.locked);
      errors++;
    end
    step(1'b1, 3'b011);
    checks++;
    if (bus.locked !== 1'b0) begin
      $display("FAIL relock_early got %0b want 0", bus.locked);
      errors++;
    end
    step(1'b1, 3'b010);
    checks++;
    if (bus.locked !== 1'b1 || bus.err_count !== 8'd1 || bus.err !== 1'b0) begin
      $display("FAIL relock_done got lk=%0b cnt=%0d err=%0b want lk=1 cnt=1 err=0",
               bus.locked, bus.err_count, bus.err);
      errors++;
    end
  endtask

  task automatic test_back_to_back_bad();
    do_reset();
    lock_to_010();
    step(1'b1, 3'b000);
    step(1'b1, 3'b111);
    checks++;
    if (bus.err !== 1'b0 || bus.err_count !== 8'd1 || bus.index !== 3'd5) begin
      $display("FAIL b2b_bad got err=%0b cnt=%0d idx=%0d want err=0 cnt=1 idx=5",
               bus.err, bus.err_count, bus.index);
      errors++;
    end
  endtask

  task automatic test_saturation();
    logic [1:0] exp_s [5];
    exp_s = '{2'd1, 2'd2, 2'd3, 2'd3, 2'd3};
    do_reset();
    lock_to_010();
    for (int i = 0; i < 5; i++) begin
      step(1'b1, 3'b000);
      checks++;
      if (bus_s.err_count !== exp_s[i] || bus_s.err !== 1'b1) begin
        $display("FAIL sat_count2 round %0d got cnt=%0d err=%0b want cnt=%0d err=1",
                 i, bus_s.err_count, bus_s.err, exp_s[i]);
        errors++;
      end
      checks++;
      if (bus.err_count !== 8'(i + 1)) begin
        $display("FAIL sat_count8 round %0d got %0d want %0d", i, bus.err_count, i + 1);
        errors++;
      end
      step(1'b1, 3'b001);
      step(1'b1, 3'b011);
      step(1'b1, 3'b010);
      checks++;
      if (bus_s.locked !== 1'b1) begin
        $display("FAIL sat_relock round %0d got %0b want 1", i, bus_s.locked);
        errors++;
      end
    end
  endtask

  task automatic test_valid_gaps();
    logic [2:0] codes [5];
    logic [2:0] idx   [5];
    logic [2:0] cur;
    int         gaps;
    codes = '{3'b110, 3'b111, 3'b101, 3'b100, 3'b000};
    idx   = '{3'd4, 3'd5, 3'd6, 3'd7, 3'd0};
    do_reset();
    lock_to_010();
    cur = 3'd3;
    for (int i = 0; i < 5; i++) begin
      gaps = $urandom_range(3, 1);
      for (int g = 0; g < gaps; g++) begin
        step(1'b0, 3'($urandom_range(7, 0)));
        checks++;
        if (bus.index !== cur || bus.locked !== 1'b1 || bus.err !== 1'b0) begin
          $display("FAIL gap_idle step %0d got idx=%0d lk=%0b err=%0b want idx=%0d lk=1 err=0",
                   i, bus.index, bus.locked, bus.err, cur);
          errors++;
        end
      end
      step(1'b1, codes[i]);
      cur = idx[i];
      checks++;
      if (bus.index !== cur || bus.locked !== 1'b1 || bus.err !== 1'b0) begin
        $display("FAIL gap_valid step %0d got idx=%0d lk=%0b err=%0b want idx=%0d lk=1 err=0",
                 i, bus.index, bus.locked, bus.err, cur);
        errors++;
      end
    end
  endtask

  task automatic test_stuck();
    logic exp_stuck;
    do_reset();
    lock_to_010();
    for (int k = 1; k <= 16; k++) begin
      step(1'b1, 3'b010);
`ifdef GRAY3_CHK_STUCK_EN
      exp_stuck = (k == 16);
`else
      exp_stuck = 1'b0;
`endif
      if (k >= 15) begin
        checks++;
        if (bus.stuck !== exp_stuck || bus.locked !== 1'b1) begin
          $display("FAIL stuck_hold repeat %0d got stk=%0b lk=%0b want stk=%0b lk=1",
                   k, bus.stuck, bus.locked, exp_stuck);
          errors++;
        end
      end
    end
    step(1'b1, 3'b110);
    checks++;
    if (bus.stuck !== 1'b0 || bus.locked !== 1'b1 || bus.index !== 3'd4) begin
      $display("FAIL stuck_release got stk=%0b lk=%0b idx=%0d want stk=0 lk=1 idx=4",
               bus.stuck, bus.locked, bus.index);
      errors++;
    end
  endtask

  task automatic test_async_reset();
    logic [2:0] codes [4];
    logic [2:0] idx   [4];
    logic       lk    [4];
    codes = '{3'b101, 3'b100, 3'b000, 3'b001};
    idx   = '{3'd6, 3'd7, 3'd0, 3'd1};
    lk    = '{1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    lock_to_010();
    for (int r = 0; r < 2; r++) begin
      step(1'b1, 3'b000);
      step(1'b1, 3'b001);
      step(1'b1, 3'b011);
      step(1'b1, 3'b010);
    end
    checks++;
    if (bus.err_count !== 8'd2 || bus.locked !== 1'b1 || bus.index !== 3'd3) begin
      $display("FAIL areset_pre got cnt=%0d lk=%0b idx=%0d want cnt=2 lk=1 idx=3",
               bus.err_count, bus.locked, bus.index);
      errors++;
    end
    #2;
    clr = 1'b1;
    #1;
    checks++;
    if (bus.index !== 3'd0 || bus.locked !== 1'b0 || bus.err !== 1'b0 ||
        bus.err_count !== 8'd0 || bus.stuck !== 1'b0 || dbg_state !== 2'd0) begin
      $display("FAIL areset_immediate got idx=%0d lk=%0b err=%0b cnt=%0d stk=%0b st=%0d want all 0",
               bus.index, bus.locked, bus.err, bus.err_count, bus.stuck, dbg_state);
      errors++;
    end
    @(negedge clk);
    clr = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step(1'b1, codes[i]);
      checks++;
      if (bus.index !== idx[i] || bus.locked !== lk[i] || bus.err !== 1'b0) begin
        $display("FAIL areset_relock step %0d got idx=%0d lk=%0b err=%0b want idx=%0d lk=%0b err=0",
                 i, bus.index, bus.locked, bus.err, idx[i], lk[i]);
        errors++;
      end
    end
  endtask

  initial begin
    checks   = 0;
    errors   = 0;
    clr      = 1'b1;
    tb_valid = 1'b0;
    tb_code  = 3'd0;
    test_reset();
    test_lockup();
    test_error_relock();
    test_back_to_back_bad();
    test_saturation();
    test_valid_gaps();
    test_stuck();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
